// File: rtl/p4_router_policer_dropper.sv
// p4_router_policer_dropper
//
// Enforcement stage behind the ingress policer. Reads the policer drop mark
// from the tuser metadata of the first beat of each packet. Every beat of a
// marked packet is discarded. Unmarked packets pass through a one-stage
// AXIS register slice with full backpressure. Saturating drop and pass
// statistics are kept for software.
//
// Ports:
//   clk, aresetn       clock, asynchronous active-low reset
//   enable             0: ignore drop marks, forward everything
//   counter_clear      one-cycle pulse, zeroes all counters (beats increments)
//   packet_in_*        AXIS slave (tdata/tstrb/tkeep/tlast/tid/tdest/tuser)
//   packet_out_*       AXIS master, registered copy of passed beats
//   drop_pkt_cnt       per-ingress-port dropped packet counts
//   drop_byte_cnt      sum of metadata byte_length over dropped packets
//   pass_pkt_cnt       forwarded packet count
//
// tuser carries the wrapper metadata as a flat vector; the field positions
// of policer_drop_mark, ingress_port and byte_length are parameters.
module p4_router_policer_dropper #(
  parameter int          NUM_ING_PORTS  = 0,
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter int unsigned DATA_BYTES     = 8,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned DEST_WIDTH     = 4,
  parameter int unsigned USER_WIDTH     = 64,
  parameter int unsigned DROP_MARK_BIT  = 0,
  parameter int unsigned PORT_LSB       = 8,
  parameter int unsigned PORT_WIDTH     = 8,
  parameter int unsigned BYTE_LEN_LSB   = 16,
  parameter int unsigned BYTE_LEN_WIDTH = 16,
  // Keeps the counter array legal while the elaboration check reports a bad
  // NUM_ING_PORTS.
  localparam int         NumPorts       = (NUM_ING_PORTS > 0) ? NUM_ING_PORTS : 1
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic                                   enable,
  input  logic                                   counter_clear,

  input  logic                                   packet_in_tvalid,
  output logic                                   packet_in_tready,
  input  logic [8*DATA_BYTES-1:0]                packet_in_tdata,
  input  logic [DATA_BYTES-1:0]                  packet_in_tstrb,
  input  logic [DATA_BYTES-1:0]                  packet_in_tkeep,
  input  logic                                   packet_in_tlast,
  input  logic [ID_WIDTH-1:0]                    packet_in_tid,
  input  logic [DEST_WIDTH-1:0]                  packet_in_tdest,
  input  logic [USER_WIDTH-1:0]                  packet_in_tuser,

  output logic                                   packet_out_tvalid,
  input  logic                                   packet_out_tready,
  output logic [8*DATA_BYTES-1:0]                packet_out_tdata,
  output logic [DATA_BYTES-1:0]                  packet_out_tstrb,
  output logic [DATA_BYTES-1:0]                  packet_out_tkeep,
  output logic                                   packet_out_tlast,
  output logic [ID_WIDTH-1:0]                    packet_out_tid,
  output logic [DEST_WIDTH-1:0]                  packet_out_tdest,
  output logic [USER_WIDTH-1:0]                  packet_out_tuser,

  output logic [NumPorts-1:0][COUNTER_WIDTH-1:0] drop_pkt_cnt,
  output logic [COUNTER_WIDTH-1:0]               drop_byte_cnt,
  output logic [COUNTER_WIDTH-1:0]               pass_pkt_cnt
);

  // Elaboration checks. Both streams share DATA_BYTES by construction here.
  if (NUM_ING_PORTS <= 0) begin : g_bad_ports
    $error("NUM_ING_PORTS must be greater than 0");
  end
  if (PORT_WIDTH > 32) begin : g_bad_port_width
    $error("PORT_WIDTH must not exceed 32");
  end

  localparam int unsigned SumWidth =
      ((COUNTER_WIDTH > BYTE_LEN_WIDTH) ? COUNTER_WIDTH : BYTE_LEN_WIDTH) + 1;

  typedef enum logic [1:0] {StSop, StPass, StDrop} state_e;

  state_e state_q, state_d;

  logic                    out_tvalid_q, out_tvalid_d;
  logic [8*DATA_BYTES-1:0] out_tdata_q,  out_tdata_d;
  logic [DATA_BYTES-1:0]   out_tstrb_q,  out_tstrb_d;
  logic [DATA_BYTES-1:0]   out_tkeep_q,  out_tkeep_d;
  logic                    out_tlast_q,  out_tlast_d;
  logic [ID_WIDTH-1:0]     out_tid_q,    out_tid_d;
  logic [DEST_WIDTH-1:0]   out_tdest_q,  out_tdest_d;
  logic [USER_WIDTH-1:0]   out_tuser_q,  out_tuser_d;

  logic [NumPorts-1:0][COUNTER_WIDTH-1:0] drop_pkt_cnt_q, drop_pkt_cnt_d;
  logic [COUNTER_WIDTH-1:0]               drop_byte_cnt_q, drop_byte_cnt_d;
  logic [COUNTER_WIDTH-1:0]               pass_pkt_cnt_q, pass_pkt_cnt_d;

  logic                      sop_drop;
  logic                      drop_beat;
  logic                      out_free;
  logic                      in_accept;
  logic                      sop_accept;
  logic                      load;
  logic [31:0]               port_ext;
  logic [BYTE_LEN_WIDTH-1:0] byte_len;
  logic [SumWidth-1:0]       byte_sum;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Handshake and FSM
  always_comb begin
    sop_drop   = enable & packet_in_tuser[DROP_MARK_BIT];
    out_free   = ~out_tvalid_q | packet_out_tready;
    drop_beat  = (state_q == StDrop) | ((state_q == StSop) & sop_drop);
    // Dropped beats never touch the output slice, so they ignore backpressure.
    packet_in_tready = aresetn & (drop_beat | out_free);
    in_accept  = packet_in_tvalid & packet_in_tready;
    sop_accept = in_accept & (state_q == StSop);
    load       = in_accept & ~drop_beat;

    state_d = state_q;
    if (in_accept) begin
      unique case (state_q)
        StSop: begin
          if (!packet_in_tlast) state_d = sop_drop ? StDrop : StPass;
        end
        StPass, StDrop: begin
          if (packet_in_tlast) state_d = StSop;
        end
        default: state_d = StSop;
      endcase
    end
  end

  // Output register slice
  always_comb begin
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tstrb_d  = out_tstrb_q;
    out_tkeep_d  = out_tkeep_q;
    out_tlast_d  = out_tlast_q;
    out_tid_d    = out_tid_q;
    out_tdest_d  = out_tdest_q;
    out_tuser_d  = out_tuser_q;
    if (load) begin
      out_tvalid_d = 1'b1;
      out_tdata_d  = packet_in_tdata;
      out_tstrb_d  = packet_in_tstrb;
      out_tkeep_d  = packet_in_tkeep;
      out_tlast_d  = packet_in_tlast;
      out_tid_d    = packet_in_tid;
      out_tdest_d  = packet_in_tdest;
      out_tuser_d  = packet_in_tuser;
    end else if (packet_out_tready) begin
      out_tvalid_d = 1'b0;
    end
  end

  // Statistics, updated once per packet on the accepted SOP beat
  always_comb begin
    drop_pkt_cnt_d  = drop_pkt_cnt_q;
    drop_byte_cnt_d = drop_byte_cnt_q;
    pass_pkt_cnt_d  = pass_pkt_cnt_q;
    port_ext = 32'(packet_in_tuser[PORT_LSB +: PORT_WIDTH]);
    byte_len = packet_in_tuser[BYTE_LEN_LSB +: BYTE_LEN_WIDTH];
    byte_sum = SumWidth'(drop_byte_cnt_q) + SumWidth'(byte_len);

    if (counter_clear) begin
      drop_pkt_cnt_d  = '0;
      drop_byte_cnt_d = '0;
      pass_pkt_cnt_d  = '0;
    end else if (sop_accept) begin
      if (sop_drop) begin
        // Out-of-range ports match no entry: byte total only.
        for (int p = 0; p < NumPorts; p++) begin
          if (port_ext == 32'(p)) drop_pkt_cnt_d[p] = sat_inc(drop_pkt_cnt_q[p]);
        end
        if (|byte_sum[SumWidth-1:COUNTER_WIDTH]) drop_byte_cnt_d = '1;
        else                                     drop_byte_cnt_d = byte_sum[COUNTER_WIDTH-1:0];
      end else begin
        pass_pkt_cnt_d = sat_inc(pass_pkt_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= StSop;
      out_tvalid_q    <= 1'b0;
      out_tdata_q     <= '0;
      out_tstrb_q     <= '1;
      out_tkeep_q     <= '1;
      out_tlast_q     <= 1'b0;
      out_tid_q       <= '0;
      out_tdest_q     <= '0;
      out_tuser_q     <= '0;
      drop_pkt_cnt_q  <= '0;
      drop_byte_cnt_q <= '0;
      pass_pkt_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      out_tvalid_q    <= out_tvalid_d;
      out_tdata_q     <= out_tdata_d;
      out_tstrb_q     <= out_tstrb_d;
      out_tkeep_q     <= out_tkeep_d;
      out_tlast_q     <= out_tlast_d;
      out_tid_q       <= out_tid_d;
      out_tdest_q     <= out_tdest_d;
      out_tuser_q     <= out_tuser_d;
      drop_pkt_cnt_q  <= drop_pkt_cnt_d;
      drop_byte_cnt_q <= drop_byte_cnt_d;
      pass_pkt_cnt_q  <= pass_pkt_cnt_d;
    end
  end

  assign packet_out_tvalid = out_tvalid_q;
  assign packet_out_tdata  = out_tdata_q;
  assign packet_out_tstrb  = out_tstrb_q;
  assign packet_out_tkeep  = out_tkeep_q;
  assign packet_out_tlast  = out_tlast_q;
  assign packet_out_tid    = out_tid_q;
  assign packet_out_tdest  = out_tdest_q;
  assign packet_out_tuser  = out_tuser_q;
  assign drop_pkt_cnt      = drop_pkt_cnt_q;
  assign drop_byte_cnt     = drop_byte_cnt_q;
  assign pass_pkt_cnt      = pass_pkt_cnt_q;

endmodule

// File: tb/tb_p4_router_policer_dropper.sv
// Directed bench for p4_router_policer_dropper. tuser layout used here:
// [0] policer_drop_mark, [7:4] ingress_port, [31:16] byte_length.
module tb_p4_router_policer_dropper;

  localparam int NP = 4;
  localparam int CW = 10;
  localparam int BW = 81;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b1;
  logic          counter_clear = 1'b0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [31:0]   in_tdata = '0;
  logic [3:0]    in_tstrb = '0;
  logic [3:0]    in_tkeep = '0;
  logic          in_tlast = 1'b0;
  logic [3:0]    in_tid = '0;
  logic [3:0]    in_tdest = '0;
  logic [31:0]   in_tuser = '0;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic [31:0]   out_tdata;
  logic [3:0]    out_tstrb;
  logic [3:0]    out_tkeep;
  logic          out_tlast;
  logic [3:0]    out_tid;
  logic [3:0]    out_tdest;
  logic [31:0]   out_tuser;
  logic [NP-1:0][CW-1:0] drop_pkt_cnt;
  logic [CW-1:0] drop_byte_cnt;
  logic [CW-1:0] pass_pkt_cnt;

  p4_router_policer_dropper #(
    .NUM_ING_PORTS(NP), .COUNTER_WIDTH(CW), .DATA_BYTES(4), .ID_WIDTH(4), .DEST_WIDTH(4),
    .USER_WIDTH(32), .DROP_MARK_BIT(0), .PORT_LSB(4), .PORT_WIDTH(4), .BYTE_LEN_LSB(16),
    .BYTE_LEN_WIDTH(16)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .counter_clear(counter_clear),
    .packet_in_tvalid(in_tvalid), .packet_in_tready(in_tready), .packet_in_tdata(in_tdata),
    .packet_in_tstrb(in_tstrb), .packet_in_tkeep(in_tkeep), .packet_in_tlast(in_tlast),
    .packet_in_tid(in_tid), .packet_in_tdest(in_tdest), .packet_in_tuser(in_tuser),
    .packet_out_tvalid(out_tvalid), .packet_out_tready(out_tready),
    .packet_out_tdata(out_tdata), .packet_out_tstrb(out_tstrb), .packet_out_tkeep(out_tkeep),
    .packet_out_tlast(out_tlast), .packet_out_tid(out_tid), .packet_out_tdest(out_tdest),
    .packet_out_tuser(out_tuser), .drop_pkt_cnt(drop_pkt_cnt), .drop_byte_cnt(drop_byte_cnt),
    .pass_pkt_cnt(pass_pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int drop_stall = 0;
  int stall_viol = 0;
  bit rand_rdy = 1'b0;
  bit stall_prev = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] cur_beat;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int exp_cyc[$];
  int got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  assign cur_beat = {out_tlast, out_tid, out_tdest, out_tuser, out_tdata, out_tstrb, out_tkeep};

  // Output monitor: records accepted beats and flags payload changes under stall.
  always @(negedge clk) begin
    if (aresetn) begin
      if (stall_prev && !(out_tvalid && cur_beat == prev_beat)) stall_viol++;
      if (out_tvalid && out_tready) begin
        got_q.push_back(cur_beat);
        got_cyc.push_back(cyc);
      end
      stall_prev = out_tvalid && !out_tready;
      prev_beat  = cur_beat;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_pkt(input int nb, input bit mark, input int port, input int blen,
                          input int base, input bit send_last, input bit clr);
    bit will_drop;
    int waited;
    bit lst;
    will_drop = enable && mark;
    for (int i = 0; i < nb; i++) begin
      lst           = send_last && (i == nb - 1);
      in_tvalid     = 1'b1;
      in_tdata      = 32'((base << 8) | i);
      in_tlast      = lst;
      in_tid        = port[3:0];
      in_tdest      = 4'(i);
      in_tstrb      = lst ? 4'h3 : 4'hF;
      in_tkeep      = lst ? 4'h7 : 4'hF;
      // Later beats carry an inverted mark; only the SOP mark may matter.
      in_tuser      = {blen[15:0], 8'h00, port[3:0], 3'b000, (i == 0) ? mark : ~mark};
      counter_clear = clr && (i == 0);
      waited = 0;
      forever begin
        @(negedge clk);
        if (in_tready) break;
        if (will_drop) drop_stall++;
        waited++;
        if (waited > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_tready_timeout: got 0 expected 1 (beat %0d)", i);
          in_tvalid = 1'b0;
          counter_clear = 1'b0;
          return;
        end
        step();
      end
      if (!will_drop) begin
        exp_q.push_back({in_tlast, in_tid, in_tdest, in_tuser, in_tdata, in_tstrb, in_tkeep});
        exp_cyc.push_back(cyc);
      end
      step();
      counter_clear = 1'b0;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain_and_compare(input string name, input bit check_latency);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({name, "_beat_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({name, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
      if (check_latency) chk({name, "_latency"}, 64'(got_cyc[i]), 64'(exp_cyc[i] + 1));
    end
    exp_q.delete();
    got_q.delete();
    exp_cyc.delete();
    got_cyc.delete();
  endtask

  task automatic clear_cnt();
    counter_clear = 1'b1;
    step();
    counter_clear = 1'b0;
  endtask

  task automatic chk_cnt(input string name, input int d0, input int d1, input int d2,
                         input int d3, input int db, input int pp);
    chk({name, "_drop0"}, 64'(drop_pkt_cnt[0]), 64'(d0));
    chk({name, "_drop1"}, 64'(drop_pkt_cnt[1]), 64'(d1));
    chk({name, "_drop2"}, 64'(drop_pkt_cnt[2]), 64'(d2));
    chk({name, "_drop3"}, 64'(drop_pkt_cnt[3]), 64'(d3));
    chk({name, "_drop_bytes"}, 64'(drop_byte_cnt), 64'(db));
    chk({name, "_pass"}, 64'(pass_pkt_cnt), 64'(pp));
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    in_tvalid = 1'b1;
    repeat (2) step();
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tlast", 64'(out_tlast), 64'd0);
    chk("rst_out_tdata", 64'(out_tdata), 64'd0);
    chk("rst_out_tid_tdest", 64'({out_tid, out_tdest}), 64'd0);
    chk("rst_out_tuser", 64'(out_tuser), 64'd0);
    chk("rst_out_tstrb_tkeep", 64'({out_tstrb, out_tkeep}), 64'hFF);
    chk_cnt("rst", 0, 0, 0, 0, 0, 0);
    in_tvalid = 1'b0;
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_pass();
    for (int p = 0; p < 3; p++) send_pkt(4, 1'b0, 1, 64, 16 + p, 1'b1, 1'b0);
    drain_and_compare("pass", 1'b1);
    chk_cnt("pass", 0, 0, 0, 0, 0, 3);
  endtask

  task automatic test_drop();
    clear_cnt();
    drop_stall = 0;
    send_pkt(5, 1'b1, 2, 300, 32, 1'b1, 1'b0);
    send_pkt(2, 1'b0, 1, 20, 33, 1'b1, 1'b0);
    drain_and_compare("drop", 1'b1);
    chk("drop_tready_high", 64'(drop_stall), 64'd0);
    chk_cnt("drop", 0, 0, 1, 0, 300, 1);
  endtask

  task automatic test_enable_off();
    clear_cnt();
    enable = 1'b0;
    send_pkt(3, 1'b1, 2, 90, 48, 1'b1, 1'b0);
    enable = 1'b1;
    drain_and_compare("enoff", 1'b1);
    chk_cnt("enoff", 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_single_beat();
    clear_cnt();
    send_pkt(1, 1'b1, 3, 64, 64, 1'b1, 1'b0);
    send_pkt(3, 1'b0, 0, 70, 65, 1'b1, 1'b0);
    // Port 5 is beyond NUM_ING_PORTS: dropped, bytes counted, no port counter.
    send_pkt(2, 1'b1, 5, 36, 66, 1'b1, 1'b0);
    drain_and_compare("single", 1'b1);
    chk_cnt("single", 0, 0, 0, 1, 100, 1);
  endtask

  task automatic test_back_to_back();
    clear_cnt();
    drop_stall = 0;
    stall_viol = 0;
    rand_rdy = 1'b1;
    send_pkt(3, 1'b0, 0, 11, 80, 1'b1, 1'b0);
    send_pkt(2, 1'b1, 1, 100, 81, 1'b1, 1'b0);
    send_pkt(1, 1'b0, 2, 12, 82, 1'b1, 1'b0);
    send_pkt(4, 1'b1, 3, 200, 83, 1'b1, 1'b0);
    send_pkt(1, 1'b1, 0, 10, 84, 1'b1, 1'b0);
    send_pkt(3, 1'b0, 1, 13, 85, 1'b1, 1'b0);
    send_pkt(2, 1'b0, 2, 14, 86, 1'b1, 1'b0);
    rand_rdy = 1'b0;
    out_tready = 1'b1;
    drain_and_compare("b2b", 1'b0);
    chk("b2b_stall_stable", 64'(stall_viol), 64'd0);
    chk("b2b_drop_tready_high", 64'(drop_stall), 64'd0);
    chk_cnt("b2b", 1, 1, 0, 1, 310, 4);
  endtask

  task automatic test_saturation();
    clear_cnt();
    for (int i = 0; i < 1024; i++) send_pkt(1, 1'b1, 0, 1, 96, 1'b1, 1'b0);
    step();
    chk_cnt("sat", 1023, 0, 0, 0, 1023, 0);
    clear_cnt();
    send_pkt(1, 1'b1, 0, 1000, 97, 1'b1, 1'b0);
    send_pkt(1, 1'b1, 0, 100, 98, 1'b1, 1'b0);
    step();
    chk_cnt("sat_bytes", 2, 0, 0, 0, 1023, 0);
  endtask

  task automatic test_clear_same_cycle();
    clear_cnt();
    send_pkt(1, 1'b0, 0, 5, 112, 1'b1, 1'b0);
    send_pkt(1, 1'b1, 1, 40, 113, 1'b1, 1'b0);
    drain_and_compare("clr_pre", 1'b0);
    chk_cnt("clr_pre", 0, 1, 0, 0, 40, 1);
    send_pkt(1, 1'b1, 1, 40, 114, 1'b1, 1'b1);
    step();
    chk_cnt("clr_same", 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    send_pkt(4, 1'b0, 2, 8, 128, 1'b0, 1'b0);
    drain_and_compare("rstmid_pre", 1'b0);
    send_pkt(2, 1'b0, 2, 8, 129, 1'b0, 1'b0);
    aresetn = 1'b0;
    in_tvalid = 1'b1;
    #1;
    chk("rstmid_in_tready", 64'(in_tready), 64'd0);
    chk("rstmid_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rstmid_out_tstrb", 64'(out_tstrb), 64'hF);
    chk("rstmid_out_tdata", 64'(out_tdata), 64'd0);
    in_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    exp_q.delete();
    exp_cyc.delete();
    got_q.delete();
    got_cyc.delete();
    // FSM must be in SOP again, so this marked packet is dropped.
    send_pkt(2, 1'b1, 3, 50, 130, 1'b1, 1'b0);
    drain_and_compare("rstmid_post", 1'b0);
    chk_cnt("rstmid", 0, 0, 0, 1, 50, 0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_drop();
    test_enable_off();
    test_single_beat();
    test_back_to_back();
    test_saturation();
    test_clear_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
